// File: rtl/sell_vend_ctrl.sv
// sell_vend_ctrl: vending transaction controller with credit, dispense, change return and buy_finish
module sell_vend_ctrl #(
  parameter int CREDIT_W        = 8,
  parameter int MAX_CREDIT      = 99,
  parameter int DISPENSE_CYCLES = 8,
  parameter int FINISH_HOLD     = 4,
  parameter int TIMEOUT_CYCLES  = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_1,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic [CREDIT_W-1:0] price,
  input  logic                buy,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy,
  output logic                buy_finish
);
  localparam int SW = CREDIT_W + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(DISPENSE_CYCLES + FINISH_HOLD + 1);
  typedef enum logic [2:0] {IDLE, CREDIT, VEND, REFUND, DONE} state_t;
  state_t        state;
  logic          vend, phase, any_coin, fits, buy_ok;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [SW-1:0] sum, tot;
  // coin total, fit check against the credit ceiling and buy acceptance, all one bit wider than credit
  always_comb begin
    any_coin = coin_1 | coin_5 | coin_10;
    sum      = SW'(coin_1) + (coin_5 ? SW'(5) : '0) + (coin_10 ? SW'(10) : '0);
    tot      = {1'b0, credit} + sum;
    fits     = tot <= SW'(MAX_CREDIT);
    buy_ok   = buy && price != '0 && credit >= price;
  end
  // transaction FSM; coins are rejected by default and only cleared where they are accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= '0;
      dispense     <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
      buy_finish   <= 1'b0;
      vend         <= 1'b0;
      phase        <= 1'b0;
      cnt          <= '0;
      tmo          <= '0;
    end else begin
      coin_reject <= any_coin;
      case (state)
        IDLE: if (any_coin && fits) begin
          coin_reject <= 1'b0;
          credit      <= tot[CREDIT_W-1:0];
          tmo         <= '0;
          state       <= CREDIT;
        end
        CREDIT: if (cancel) begin
          vend  <= 1'b0;
          phase <= 1'b0;
          busy  <= 1'b1;
          state <= REFUND;
        end else if (buy_ok) begin
          credit   <= credit - price;
          vend     <= 1'b1;
          cnt      <= '0;
          dispense <= 1'b1;
          busy     <= 1'b1;
          state    <= VEND;
        end else if (any_coin && fits) begin
          coin_reject <= 1'b0;
          credit      <= tot[CREDIT_W-1:0];
          tmo         <= '0;
        end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          vend  <= 1'b0;
          phase <= 1'b0;
          busy  <= 1'b1;
          state <= REFUND;
        end else tmo <= tmo + TW'(1);
        VEND: if (cnt == CW'(DISPENSE_CYCLES - 1)) begin
          dispense <= 1'b0;
          cnt      <= '0;
          phase    <= 1'b0;
          buy_finish <= credit == '0;
          state    <= credit != '0 ? REFUND : DONE;
        end else cnt <= cnt + CW'(1);
        REFUND: if (!phase) begin
          change_pulse <= 1'b1;
          credit       <= credit - CREDIT_W'(1);
          phase        <= 1'b1;
        end else begin
          change_pulse <= 1'b0;
          phase        <= 1'b0;
          if (credit == '0) begin
            cnt        <= '0;
            buy_finish <= vend;
            busy       <= vend;
            state      <= vend ? DONE : IDLE;
          end
        end
        DONE: if (cnt == CW'(FINISH_HOLD - 1)) begin
          buy_finish <= 1'b0;
          vend       <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sell_vend_ctrl.sv
// tb_sell_vend_ctrl: scoreboard bench counting dispense/change/finish cycles per transaction
module tb_sell_vend_ctrl;
  logic       clk = 0, reset = 1;
  logic       coin_1 = 0, coin_5 = 0, coin_10 = 0, buy = 0, cancel = 0;
  logic [7:0] price = 0, credit;
  logic       dispense, change_pulse, coin_reject, busy, buy_finish;
  typedef struct {int disp; int chg; int fin;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  int disp_n = 0, chg_n = 0, fin_n = 0, cyc = 0, last_chg = 0;
  logic pb = 0;

  sell_vend_ctrl #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10),
    .price(price), .buy(buy), .cancel(cancel), .credit(credit), .dispense(dispense),
    .change_pulse(change_pulse), .coin_reject(coin_reject), .busy(busy), .buy_finish(buy_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic c1, input logic c5, input logic c10, input logic b, input logic c);
    coin_1 = c1; coin_5 = c5; coin_10 = c10; buy = b; cancel = c;
    @(negedge clk);
    coin_1 = 0; coin_5 = 0; coin_10 = 0; buy = 0; cancel = 0;
  endtask

  task automatic push(input int d, input int c, input int f);
    exp_t e;
    e.disp = d; e.chg = c; e.fin = f;
    q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
    chk({tag, "_credit"}, credit, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      disp_n = 0; chg_n = 0; fin_n = 0; pb = 0;
    end else begin
      disp_n += dispense;
      fin_n  += buy_finish;
      if (change_pulse) begin
        if (chg_n > 0) chk("chg_gap", cyc - last_chg, 2);
        last_chg = cyc;
        chg_n++;
      end
      if (pb && !busy) begin
        if (q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = q.pop_front();
          chk("sb_dispense", disp_n, e.disp);
          chk("sb_change", chg_n, e.chg);
          chk("sb_finish", fin_n, e.fin);
        end
        disp_n = 0; chg_n = 0; fin_n = 0;
      end
      pb = busy;
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_credit", credit, 0);
    chk("rst_outs", {dispense, change_pulse, coin_reject, busy, buy_finish}, 0);
    reset = 0;
    // purchase with one unit of change
    pulse(0, 1, 0, 0, 0); chk("t1_c5", credit, 5);
    pulse(1, 0, 0, 0, 0); chk("t1_c6", credit, 6);
    pulse(1, 0, 0, 0, 0); chk("t1_c7", credit, 7);
    price = 6; push(8, 1, 4);
    pulse(0, 0, 0, 1, 0); chk("t1_left", credit, 1); chk("t1_disp", dispense, 1);
    wait_idle("t1_idle");
    // exact payment, no change
    pulse(0, 0, 1, 0, 0); chk("t2_c10", credit, 10);
    price = 10; push(8, 0, 4);
    pulse(0, 0, 0, 1, 0);
    wait_idle("t2_idle");
    // insufficient credit and zero price are ignored
    pulse(0, 1, 0, 0, 0);
    price = 6; pulse(0, 0, 0, 1, 0);
    chk("t3_nodisp", {dispense, busy}, 0); chk("t3_credit", credit, 5);
    price = 0; pulse(0, 0, 0, 1, 0);
    chk("t3_zero", {dispense, busy}, 0); chk("t3_credit0", credit, 5);
    push(0, 5, 0); pulse(0, 0, 0, 0, 1);
    wait_idle("t3_idle");
    // credit ceiling
    repeat (9) pulse(0, 0, 1, 0, 0);
    pulse(0, 1, 0, 0, 0); chk("t4_95", credit, 95);
    pulse(0, 0, 1, 0, 0); chk("t4_rej", coin_reject, 1); chk("t4_hold", credit, 95);
    @(negedge clk); chk("t4_rej_1cyc", coin_reject, 0);
    repeat (4) pulse(1, 0, 0, 0, 0); chk("t4_99", credit, 99);
    pulse(1, 0, 0, 0, 0); chk("t4_rej99", coin_reject, 1); chk("t4_hold99", credit, 99);
    push(0, 99, 0); pulse(0, 0, 0, 0, 1);
    wait_idle("t4_idle");
    pulse(1, 1, 0, 0, 0); chk("t4_multi", credit, 6);
    price = 6; push(8, 0, 4); pulse(0, 0, 0, 1, 0);
    pulse(0, 0, 1, 0, 0); chk("t4_vend_rej", coin_reject, 1); chk("t4_vend_credit", credit, 0);
    wait_idle("t4_vend_idle");
    // cancel wins over buy
    pulse(0, 1, 0, 0, 0); pulse(1, 0, 0, 0, 0); pulse(1, 0, 0, 0, 0);
    price = 6; push(0, 7, 0);
    pulse(0, 0, 0, 1, 1); chk("t5_nodisp", dispense, 0);
    wait_idle("t5_idle");
    // inactivity timeout refund
    repeat (3) pulse(1, 0, 0, 0, 0); chk("t6_c3", credit, 3);
    push(0, 3, 0);
    n = 0;
    while (!busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_tmo_cycles", n, 20);
    wait_idle("t6_idle");
    // reset in the middle of a refund
    repeat (3) pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    chk("t6_mid", credit, 2);
    reset = 1;
    @(negedge clk);
    chk("t6_rst_credit", credit, 0);
    chk("t6_rst_outs", {dispense, change_pulse, busy, buy_finish}, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
